// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-access bridge: FSM states,
// command byte field positions and the burst address helper.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_WDATA_H,
    ST_WDATA_L,
    ST_WR_STB,
    ST_RD_STB,
    ST_RD_WAIT,
    ST_TX_H,
    ST_TX_L
  } bridge_state_e;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 4;
  localparam int CMD_LEN_MSB = 3;
  localparam int CMD_LEN_LSB = 0;
  localparam int BURST_MAX   = 16;
  localparam int LEN_W       = $clog2(BURST_MAX);
  localparam int OFS_W       = 12;

  // Offset wraps inside the 4 KiB window; block select never changes mid-burst.
  function automatic logic [15:0] next_word_addr(input logic [15:0] addr);
    return {addr[15:OFS_W], addr[OFS_W-1:0] + OFS_W'(1)};
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: reloads on clear or while idle, counts down while
// running and flags expiry once TIMEOUT_CYC cycles pass without a byte.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// Host command responder: parses UART command frames, drives the local
// register bus and streams read data back to the UART transmitter.
//
// state          | meaning
// IDLE           | waiting for CMD byte
// ADDR_H/ADDR_L  | collecting start address
// WDATA_H/L      | collecting one write word
// WR_STB/RD_STB  | one-cycle register bus strobe
// RD_WAIT        | capturing reg_rdata
// TX_H/TX_L      | returning read word, MSB first
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] reg_addr,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        frame_err
);

  bridge_state_e state, state_nxt;

  logic             cmd_wr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [7:0]       addr_h_q;
  logic [7:0]       wdata_h_q;
  logic [15:0]      rdata_q;

  logic err_nxt;
  logic cap_cmd, cap_addr_h, cap_addr_l, cap_wdata_h, cap_wdata_l, cap_rdata;
  logic adv_word;
  logic tmo_run, tmo_expired, abort, word_last;

  assign tmo_run   = state inside {ST_ADDR_H, ST_ADDR_L, ST_WDATA_H, ST_WDATA_L};
  assign abort     = rx_valid ? rx_perr : tmo_expired;
  assign word_last = (word_cnt == len_q);

  uart_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_valid),
    .run    (tmo_run),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    err_nxt     = 1'b0;
    cap_cmd     = 1'b0;
    cap_addr_h  = 1'b0;
    cap_addr_l  = 1'b0;
    cap_wdata_h = 1'b0;
    cap_wdata_l = 1'b0;
    cap_rdata   = 1'b0;
    adv_word    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_perr || (rx_data[CMD_RSV_MSB:CMD_RSV_LSB] != '0)) begin
            err_nxt = 1'b1;
          end else begin
            cap_cmd   = 1'b1;
            state_nxt = ST_ADDR_H;
          end
        end
      end

      ST_ADDR_H: begin
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_valid) begin
          cap_addr_h = 1'b1;
          state_nxt  = ST_ADDR_L;
        end
      end

      ST_ADDR_L: begin
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_valid) begin
          cap_addr_l = 1'b1;
          state_nxt  = cmd_wr_q ? ST_WDATA_H : ST_RD_STB;
        end
      end

      ST_WDATA_H: begin
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_valid) begin
          cap_wdata_h = 1'b1;
          state_nxt   = ST_WDATA_L;
        end
      end

      ST_WDATA_L: begin
        if (abort) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rx_valid) begin
          cap_wdata_l = 1'b1;
          state_nxt   = ST_WR_STB;
        end
      end

      // A byte landing on the strobe cycle has nowhere to go.
      ST_WR_STB: begin
        err_nxt = rx_valid;
        if (word_last) begin
          state_nxt = ST_IDLE;
        end else begin
          adv_word  = 1'b1;
          state_nxt = ST_WDATA_H;
        end
      end

      ST_RD_STB: begin
        err_nxt   = rx_valid;
        state_nxt = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        err_nxt   = rx_valid;
        cap_rdata = 1'b1;
        state_nxt = ST_TX_H;
      end

      ST_TX_H: begin
        err_nxt = rx_valid;
        if (tx_ready) begin
          state_nxt = ST_TX_L;
        end
      end

      ST_TX_L: begin
        err_nxt = rx_valid;
        if (tx_ready) begin
          if (word_last) begin
            state_nxt = ST_IDLE;
          end else begin
            adv_word  = 1'b1;
            state_nxt = ST_RD_STB;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_wr_q  <= 1'b0;
      len_q     <= '0;
      word_cnt  <= '0;
      addr_h_q  <= '0;
      wdata_h_q <= '0;
      rdata_q   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      if (cap_cmd) begin
        cmd_wr_q <= rx_data[CMD_WR_BIT];
        len_q    <= rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
        word_cnt <= '0;
      end
      if (cap_addr_h) begin
        addr_h_q <= rx_data;
      end
      if (cap_addr_l) begin
        reg_addr <= {addr_h_q, rx_data};
      end
      if (cap_wdata_h) begin
        wdata_h_q <= rx_data;
      end
      if (cap_wdata_l) begin
        reg_wdata <= {wdata_h_q, rx_data};
      end
      if (cap_rdata) begin
        rdata_q <= reg_rdata;
      end
      if (adv_word) begin
        word_cnt <= word_cnt + LEN_W'(1);
        reg_addr <= next_word_addr(reg_addr);
      end
    end
  end

  assign reg_wr   = (state == ST_WR_STB);
  assign reg_rd   = (state == ST_RD_STB);
  assign tx_valid = (state == ST_TX_H) || (state == ST_TX_L);

  always_comb begin
    tx_data = 8'h00;
    if (state == ST_TX_H) begin
      tx_data = rdata_q[15:8];
    end else if (state == ST_TX_L) begin
      tx_data = rdata_q[7:0];
    end
  end

endmodule
